// File: rtl/imm_narrow_21.sv
// imm_narrow_21: narrows 32-bit signed immediates to a 21-bit field (saturate or truncate),
// queues data+overflow in a small FIFO and counts overflowing words.
module imm_narrow_21 #(
  parameter bit SAT   = 1'b1,
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] IN_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [20:0] OUT_DATA,
  output logic        OUT_OVF,
  output logic [7:0]  OVF_CNT,
  input  logic        OVF_CLR
);
  localparam int AW = $clog2(DEPTH);
  logic [21:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [7:0]    ovf_q, ovf_d;
  logic          fits, push, pop;
  logic [20:0]   nar;
  assign fits = &IN_DATA[31:20] || ~|IN_DATA[31:20];
  assign nar = (fits || !SAT) ? IN_DATA[20:0] : (IN_DATA[31] ? 21'h100000 : 21'h0FFFFF);
  // DEPTH is a power of two, so the occupancy MSB alone means full
  assign IN_READY = !cnt_q[AW] && !RST;
  assign OUT_VALID = |cnt_q;
  assign push = IN_VALID && IN_READY;
  assign pop = OUT_VALID && OUT_READY;
  assign OUT_DATA = OUT_VALID ? mem_q[rd_q][20:0] : '0;
  assign OUT_OVF = OUT_VALID && mem_q[rd_q][21];
  assign OVF_CNT = ovf_q;
  always_comb begin
    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    ovf_d = OVF_CLR ? '0 : (push && !fits && !(&ovf_q)) ? ovf_q + 8'd1 : ovf_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      ovf_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_q] <= {!fits, nar};
  end
endmodule
